// File: rtl/mux_sched_pkg.sv
// Shared definitions for the 16-source round-robin byte scheduler.
package mux_sched_pkg;

  localparam int NUM_SRC = 16;
  localparam int SEL_W   = 4;
  localparam int DATA_W  = 8;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

endpackage : mux_sched_pkg

// File: rtl/mux16_1_8b_struc.sv
// Structural 16:1 mux of 8-bit lanes, built as a four-level tree of 2:1 stages.
module mux16_1_8b_struc (
  input  logic [7:0] d0,
  input  logic [7:0] d1,
  input  logic [7:0] d2,
  input  logic [7:0] d3,
  input  logic [7:0] d4,
  input  logic [7:0] d5,
  input  logic [7:0] d6,
  input  logic [7:0] d7,
  input  logic [7:0] d8,
  input  logic [7:0] d9,
  input  logic [7:0] d10,
  input  logic [7:0] d11,
  input  logic [7:0] d12,
  input  logic [7:0] d13,
  input  logic [7:0] d14,
  input  logic [7:0] d15,
  input  logic       sel3,
  input  logic       sel2,
  input  logic       sel1,
  input  logic       sel0,
  output logic [7:0] y
);

  logic [7:0] lvl0 [16];
  logic [7:0] lvl1 [8];
  logic [7:0] lvl2 [4];
  logic [7:0] lvl3 [2];

  assign lvl0[0]  = d0;
  assign lvl0[1]  = d1;
  assign lvl0[2]  = d2;
  assign lvl0[3]  = d3;
  assign lvl0[4]  = d4;
  assign lvl0[5]  = d5;
  assign lvl0[6]  = d6;
  assign lvl0[7]  = d7;
  assign lvl0[8]  = d8;
  assign lvl0[9]  = d9;
  assign lvl0[10] = d10;
  assign lvl0[11] = d11;
  assign lvl0[12] = d12;
  assign lvl0[13] = d13;
  assign lvl0[14] = d14;
  assign lvl0[15] = d15;

  for (genvar g = 0; g < 8; g++) begin : g_l1
    assign lvl1[g] = sel0 ? lvl0[2*g+1] : lvl0[2*g];
  end
  for (genvar g = 0; g < 4; g++) begin : g_l2
    assign lvl2[g] = sel1 ? lvl1[2*g+1] : lvl1[2*g];
  end
  for (genvar g = 0; g < 2; g++) begin : g_l3
    assign lvl3[g] = sel2 ? lvl2[2*g+1] : lvl2[2*g];
  end

  assign y = sel3 ? lvl3[1] : lvl3[0];

endmodule : mux16_1_8b_struc

// File: rtl/mux16_rr_sched.sv
// Round-robin scheduler sharing one 16:1 byte mux among 16 requesters,
// with a registered valid/ready output and bounded per-winner bursts.
module mux16_rr_sched
  import mux_sched_pkg::*;
#(
  parameter int MAX_BURST = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC-1:0]        req,
  input  logic [NUM_SRC*DATA_W-1:0] din,
  input  logic                      out_ready,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  output logic [SEL_W-1:0]          out_src,
  output logic [NUM_SRC-1:0]        grant,
  output logic                      busy
);

  if (MAX_BURST < 1 || MAX_BURST > 16) begin : g_bad_burst
    $error("mux16_rr_sched: MAX_BURST=%0d outside 1..16", MAX_BURST);
  end

  localparam logic [4:0] BURST_LIM = 5'(MAX_BURST);

  // First requester at or after base, wrapping 15 -> 0; returns base if none.
  function automatic logic [SEL_W-1:0] rr_pick(input logic [NUM_SRC-1:0] r,
                                                input logic [SEL_W-1:0]   base);
    logic [SEL_W-1:0] idx;
    logic             found;
    rr_pick = base;
    found   = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = base + SEL_W'(k);
      if (!found && r[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  state_t           state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [4:0]       beat_cnt, beat_d;
  logic [SEL_W-1:0] src_d;
  logic             valid_d;
  logic             load;
  logic             hs, cont, rearb;
  logic [SEL_W-1:0] arb_base, winner, mux_sel;
  logic [DATA_W-1:0] mux_y;

  assign hs       = out_valid & out_ready;
  assign cont     = req[out_src] && (beat_cnt < BURST_LIM);
  // When a burst ends the new pointer is out_src+1, so search from there now.
  assign arb_base = (state_q == IDLE) ? ptr_q : out_src + SEL_W'(1);
  assign winner   = rr_pick(req, arb_base);
  assign rearb    = (state_q == IDLE) || (hs && !cont);
  assign mux_sel  = rearb ? winner : out_src;

  mux16_1_8b_struc u_mux (
    .d0  (din[0*DATA_W  +: DATA_W]),
    .d1  (din[1*DATA_W  +: DATA_W]),
    .d2  (din[2*DATA_W  +: DATA_W]),
    .d3  (din[3*DATA_W  +: DATA_W]),
    .d4  (din[4*DATA_W  +: DATA_W]),
    .d5  (din[5*DATA_W  +: DATA_W]),
    .d6  (din[6*DATA_W  +: DATA_W]),
    .d7  (din[7*DATA_W  +: DATA_W]),
    .d8  (din[8*DATA_W  +: DATA_W]),
    .d9  (din[9*DATA_W  +: DATA_W]),
    .d10 (din[10*DATA_W +: DATA_W]),
    .d11 (din[11*DATA_W +: DATA_W]),
    .d12 (din[12*DATA_W +: DATA_W]),
    .d13 (din[13*DATA_W +: DATA_W]),
    .d14 (din[14*DATA_W +: DATA_W]),
    .d15 (din[15*DATA_W +: DATA_W]),
    .sel3(mux_sel[3]),
    .sel2(mux_sel[2]),
    .sel1(mux_sel[1]),
    .sel0(mux_sel[0]),
    .y   (mux_y)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    state_d = state_q;
    ptr_d   = ptr_q;
    beat_d  = beat_cnt;
    valid_d = out_valid;
    load    = 1'b0;
    if (state_q == IDLE) begin
      if (|req) begin
        load    = 1'b1;
        valid_d = 1'b1;
        beat_d  = 5'd1;
        state_d = XFER;
      end
    end else if (hs) begin
      if (cont) begin
        load   = 1'b1;
        beat_d = beat_cnt + 5'd1;
      end else begin
        ptr_d = out_src + SEL_W'(1);
        if (|req) begin
          load   = 1'b1;
          beat_d = 5'd1;
        end else begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
    end
    src_d = load ? mux_sel : out_src;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      out_src   <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      beat_cnt  <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      out_src   <= src_d;
      out_valid <= valid_d;
      beat_cnt  <= beat_d;
      if (load) out_data <= mux_y;
    end
  end

  assign grant = hs ? (NUM_SRC'(1) << out_src) : '0;
  assign busy  = (state_q != IDLE);

endmodule : mux16_rr_sched

// File: tb/tb_mux16_rr_sched.sv
// Directed bench: two instances (MAX_BURST=1 and 4) share one stimulus stream.
module tb_mux16_rr_sched;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [15:0]  req = '0;
  logic [127:0] din = '0;
  logic         out_ready = 1'b0;

  logic        v1, b1, v4, b4;
  logic [7:0]  d1, d4;
  logic [3:0]  s1, s4;
  logic [15:0] g1, g4;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mux16_rr_sched #(.MAX_BURST(1)) dut1 (
    .clk(clk), .rst(rst), .req(req), .din(din), .out_ready(out_ready),
    .out_valid(v1), .out_data(d1), .out_src(s1), .grant(g1), .busy(b1)
  );

  mux16_rr_sched #(.MAX_BURST(4)) dut4 (
    .clk(clk), .rst(rst), .req(req), .din(din), .out_ready(out_ready),
    .out_valid(v4), .out_data(d4), .out_src(s4), .grant(g4), .busy(b4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int exp_b [15];
    exp_b = '{1, 1, 1, 1, 2, 2, 2, 2, 1, 1, 1, 1, 2, 2, 1};

    // 1. reset with every source requesting
    rst = 1'b1; req = 16'hFFFF; out_ready = 1'b1;
    tick(); #1;
    check("rst_valid_a", 32'(v1), 0);
    check("rst_grant_a", 32'(g1), 0);
    check("rst_busy_a",  32'(b1), 0);
    tick(); #1;
    check("rst_valid_b", 32'(v1), 0);
    check("rst_grant_b", 32'(g1), 0);
    check("rst_busy_b",  32'(b4), 0);
    rst = 1'b0; out_ready = 1'b0;
    tick(); #1;
    check("rst_first_src1", 32'(s1), 0);
    check("rst_first_src4", 32'(s4), 0);
    check("rst_first_valid", 32'(v1), 1);
    check("rst_first_busy",  32'(b1), 1);

    // 2. single source 8
    do_reset();
    din[8*8 +: 8] = 8'h61;
    req = 16'h0100; out_ready = 1'b1;
    tick();
    req = 16'h0000; #1;
    check("single_valid", 32'(v1), 1);
    check("single_data",  32'(d1), 32'h61);
    check("single_src",   32'(s1), 8);
    check("single_grant", 32'(g1), 32'h0100);
    tick(); #1;
    check("single_idle_valid", 32'(v1), 0);
    check("single_idle_grant", 32'(g1), 0);
    check("single_idle_busy",  32'(b1), 0);

    // 3. round-robin over all sources, MAX_BURST=1
    do_reset();
    for (int i = 0; i < 16; i++) din[8*i +: 8] = 8'(8'h10 + i);
    req = 16'hFFFF; out_ready = 1'b1;
    tick();
    for (int k = 0; k < 17; k++) begin
      #1;
      check($sformatf("rr_src_%0d", k),   32'(s1), 32'(k % 16));
      check($sformatf("rr_valid_%0d", k), 32'(v1), 1);
      check($sformatf("rr_grant_%0d", k), 32'(g1), 32'(1) << (k % 16));
      check($sformatf("rr_data_%0d", k),  32'(d1), 32'(8'h10 + (k % 16)));
      tick();
    end

    // 4. backpressure on source 3
    do_reset();
    din[3*8 +: 8] = 8'hFE;
    req = 16'h0008; out_ready = 1'b0;
    tick();
    din[3*8 +: 8] = 8'h02;
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("bp_data_%0d", k),  32'(d1), 32'hFE);
      check($sformatf("bp_src_%0d", k),   32'(s1), 3);
      check($sformatf("bp_grant_%0d", k), 32'(g1), 0);
      check($sformatf("bp_valid_%0d", k), 32'(v1), 1);
      tick();
    end
    req = 16'h0000; out_ready = 1'b1; #1;
    check("bp_release_grant", 32'(g1), 32'h0008);
    check("bp_release_data",  32'(d1), 32'hFE);
    tick(); #1;
    check("bp_after_grant", 32'(g1), 0);
    check("bp_after_valid", 32'(v1), 0);

    // 5. bursts of four on sources 1 and 2, then source 2 drops after beat 2
    do_reset();
    req = 16'h0006; out_ready = 1'b1;
    tick();
    for (int k = 0; k < 15; k++) begin
      if (k == 13) req = 16'h0002;
      #1;
      check($sformatf("burst_src_%0d", k),   32'(s4), 32'(exp_b[k]));
      check($sformatf("burst_grant_%0d", k), 32'(g4), 32'(1) << exp_b[k]);
      tick();
    end

    // 6. pointer at 15, wrap, then reset during a stall
    do_reset();
    req = 16'h4000; out_ready = 1'b1;
    tick();
    req = 16'h8001;
    tick(); #1;
    check("wrap_src_a", 32'(s1), 15);
    check("wrap_grant_a", 32'(g1), 32'h8000);
    tick(); #1;
    check("wrap_src_b", 32'(s1), 0);
    tick(); #1;
    check("wrap_src_c", 32'(s1), 15);
    out_ready = 1'b0; #1;
    check("stall_grant", 32'(g1), 0);
    rst = 1'b1;
    tick();
    rst = 1'b0; out_ready = 1'b1; #1;
    check("mid_rst_valid", 32'(v1), 0);
    check("mid_rst_grant", 32'(g1), 0);
    check("mid_rst_busy",  32'(b1), 0);
    tick(); #1;
    check("mid_rst_restart_src", 32'(s1), 0);
    check("mid_rst_restart_valid", 32'(v1), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_mux16_rr_sched
